// File: rtl/demux2x4_buffered.sv
// Buffered 1-to-2 stream demultiplexer: each input word is steered by S into
// one of two independent circular FIFOs, each with its own ready/valid drain.

module demux2x4_buffered_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   rd_ready_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr, rd;

  always_comb begin
    full_o  = (cnt_q == CW'(DEPTH));
    valid_o = (cnt_q != '0);
    data_o  = mem_q[rptr_q];
    count_o = cnt_q;
  end

  always_comb begin
    wr = push_i && !full_o;
    rd = valid_o && rd_ready_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = wptr_q + PW'(1);
    if (rd) rptr_d = rptr_q + PW'(1);
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) mem_q[wptr_q] <= data_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

module demux2x4_buffered #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [WIDTH-1:0]       I,
  input  logic                   S,
  input  logic                   I_valid,
  output logic                   I_ready,
  output logic [WIDTH-1:0]       O0,
  output logic                   O0_valid,
  input  logic                   O0_ready,
  output logic [WIDTH-1:0]       O1,
  output logic                   O1_valid,
  input  logic                   O1_ready,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);

  logic full0, full1;
  logic push0, push1;

  // I_ready depends only on S and the registered occupancy, never on the
  // output-side ready inputs, so a full channel cannot be refilled mid-pop.
  always_comb begin
    I_ready = S ? !full1 : !full0;
    push0   = I_valid && I_ready && !S;
    push1   = I_valid && I_ready && S;
  end

  demux2x4_buffered_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch0 (
    .clk_i      (CLK),
    .rst_ni     (RESETN),
    .push_i     (push0),
    .data_i     (I),
    .rd_ready_i (O0_ready),
    .data_o     (O0),
    .valid_o    (O0_valid),
    .full_o     (full0),
    .count_o    (count0)
  );

  demux2x4_buffered_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch1 (
    .clk_i      (CLK),
    .rst_ni     (RESETN),
    .push_i     (push1),
    .data_i     (I),
    .rd_ready_i (O1_ready),
    .data_o     (O1),
    .valid_o    (O1_valid),
    .full_o     (full1),
    .count_o    (count1)
  );

endmodule
